// File: rtl/sel_display_pkg.sv
// -----------------------------------------------------------------------------
// sel_display_pkg
// Shared constants, types and helpers for the front-panel selection/display
// controller (sel_display_ctrl) and its button conditioner.
// No ports (package).
// -----------------------------------------------------------------------------
package sel_display_pkg;

  localparam logic [2:0] SEL_MIN      = 3'd0;
  localparam logic [2:0] SEL_MAX      = 3'd7;
  localparam int         NUM_DIGITS   = 4;
  localparam logic [3:0] AN_OFF       = 4'b1111;
  localparam logic       MODE_CURRENT = 1'b0;
  localparam logic       MODE_FREQ    = 1'b1;

  // Scan position on the 4-digit display; units is the rightmost digit.
  typedef enum logic [1:0] {
    DIG_UNITS     = 2'd0,
    DIG_TENS      = 2'd1,
    DIG_HUNDREDS  = 2'd2,
    DIG_THOUSANDS = 2'd3
  } digit_idx_t;

  // Active-low one-hot anode pattern for a scan position.
  function automatic logic [3:0] anode_of(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

  // Saturating selector step; opposing requests in the same cycle cancel.
  function automatic logic [2:0] sel_step(input logic [2:0] cur,
                                          input logic       up,
                                          input logic       down);
    logic [2:0] nxt;
    nxt = cur;
    if (up && !down && (cur != SEL_MAX)) begin
      nxt = cur + 3'd1;
    end else if (down && !up && (cur != SEL_MIN)) begin
      nxt = cur - 3'd1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Synchronizes one raw push-button, debounces it and emits a single-cycle
// pulse when the accepted level goes 0->1. Release gives no pulse and a held
// button gives exactly one pulse.
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  synchronous active-low reset
//   btn    in  1  raw asynchronous button, active-high
//   press  out 1  one-cycle registered press pulse
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  // Enough bits to hold DEB_CYCLES-1; at least one bit for tiny settings.
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          press_r;

  // Synchronizer, debounce counter, accepted level and press pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
      press_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      // The counter only runs while the synchronized level disagrees with the
      // accepted one; any sample that agrees again restarts it from zero.
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_MAX) begin
          level_r <= sync2_r;
          cnt_r   <= CNT_ZERO;
          press_r <= sync2_r;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= CNT_ZERO;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/sel_display_ctrl.sv
// -----------------------------------------------------------------------------
// sel_display_ctrl
// Front-panel controller: conditions up/down/mode buttons, keeps the current
// (selC) and frequency (selF) selectors plus the mode flag (enable), and scans
// the four BCD digits returned by the lookup block onto a common-anode 4-digit
// 7-segment display with leading-zero blanking.
// Ports:
//   clk       in  1  system clock
//   rst_n     in  1  synchronous active-low reset
//   btn_up    in  1  raw button, increments selected selector
//   btn_down  in  1  raw button, decrements selected selector
//   btn_mode  in  1  raw button, toggles current/frequency mode
//   r0..r3    in  4  BCD digits, r0 units .. r3 thousands
//   selC      out 3  current selector
//   selF      out 3  frequency selector
//   enable    out 1  0 = current mode, 1 = frequency mode
//   digit     out 4  BCD code of the lit digit
//   an        out 4  active-low one-hot anode enables
// -----------------------------------------------------------------------------
module sel_display_ctrl
  import sel_display_pkg::*;
#(
  parameter int DEB_CYCLES  = 500000,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mode,
  input  logic [3:0] r0,
  input  logic [3:0] r1,
  input  logic [3:0] r2,
  input  logic [3:0] r3,
  output logic [2:0] selC,
  output logic [2:0] selF,
  output logic       enable,
  output logic [3:0] digit,
  output logic [3:0] an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] REF_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] REF_ONE  = RW'(1);

  logic       up_s;
  logic       down_s;
  logic       mode_s;

  logic [2:0] selc_r;
  logic [2:0] self_r;
  logic       enable_r;
  logic [2:0] target_s;
  logic [2:0] next_target_s;

  logic [RW-1:0] refresh_r;
  digit_idx_t    idx_r;
  logic [3:0]    digit_r;
  logic [3:0]    an_r;
  logic [3:0]    digit_sel_s;
  logic          blank_s;

  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_up),
    .press (up_s)
  );

  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_down (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_down),
    .press (down_s)
  );

  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .press (mode_s)
  );

  // Pick the selector addressed by the pre-toggle mode and compute its step.
  always_comb begin
    target_s      = selc_r;
    next_target_s = selc_r;
    if (enable_r == MODE_FREQ) begin
      target_s = self_r;
    end else begin
      target_s = selc_r;
    end
    next_target_s = sel_step(target_s, up_s, down_s);
  end

  // Selector and mode registers; the unaddressed selector holds its value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      selc_r   <= SEL_MIN;
      self_r   <= SEL_MIN;
      enable_r <= MODE_CURRENT;
    end else begin
      if (enable_r == MODE_FREQ) begin
        self_r <= next_target_s;
      end else begin
        selc_r <= next_target_s;
      end
      if (mode_s) begin
        enable_r <= ~enable_r;
      end else begin
        enable_r <= enable_r;
      end
    end
  end

  // Digit mux with leading-zero blanking of the two upper positions.
  always_comb begin
    digit_sel_s = r0;
    blank_s     = 1'b0;
    case (idx_r)
      DIG_UNITS: begin
        digit_sel_s = r0;
        blank_s     = 1'b0;
      end
      DIG_TENS: begin
        digit_sel_s = r1;
        blank_s     = 1'b0;
      end
      DIG_HUNDREDS: begin
        digit_sel_s = r2;
        blank_s     = (r3 == 4'd0) && (r2 == 4'd0);
      end
      DIG_THOUSANDS: begin
        digit_sel_s = r3;
        blank_s     = (r3 == 4'd0);
      end
      default: begin
        digit_sel_s = r0;
        blank_s     = 1'b0;
      end
    endcase
  end

  // Refresh divider, scan index and registered display drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_r <= REF_ZERO;
      idx_r     <= DIG_UNITS;
      digit_r   <= 4'd0;
      an_r      <= AN_OFF;
    end else begin
      if (refresh_r == REF_MAX) begin
        refresh_r <= REF_ZERO;
        idx_r     <= digit_idx_t'(idx_r + 2'd1);
      end else begin
        refresh_r <= refresh_r + REF_ONE;
      end
      // Display follows the index one cycle later; r is sampled here.
      if (blank_s) begin
        digit_r <= 4'd0;
        an_r    <= AN_OFF;
      end else begin
        digit_r <= digit_sel_s;
        an_r    <= anode_of(idx_r);
      end
    end
  end

  assign selC   = selc_r;
  assign selF   = self_r;
  assign enable = enable_r;
  assign digit  = digit_r;
  assign an     = an_r;

endmodule
